// File: rtl/vga_fb_ctrl_pkg.sv
// Shared types and constants for the 160x60 4-bpp VGA framebuffer
// write path.
package vga_fb_ctrl_pkg;

   localparam int FB_WIDTH     = 160;
   localparam int FB_HEIGHT    = 60;
   localparam int FB_ROW_BYTES = 80;
   localparam int FB_ROWS      = 60;
   localparam int FB_WORDS     = 1200;
   localparam int FB_AW        = 13;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef struct packed {
      logic       memWrite;
      logic [1:0] size;
   } mem_ctrl_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fill_state_t;

   // y*80 built from shifts so no multiplier is inferred
   function automatic logic [FB_AW-1:0] row_base(input logic [5:0] y);
      logic [FB_AW-1:0] w_y;
      w_y = {7'd0, y};
      return (w_y << 6) + (w_y << 4);
   endfunction

endpackage

// File: rtl/vga_fill_engine.sv
// Rectangle-fill engine: walks the byte rectangle row by row and
// requests one byte write per grant.
module vga_fill_engine
   import vga_fb_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [6:0]        i_bx0,
   input  logic [6:0]        i_bx1,
   input  logic [5:0]        i_y0,
   input  logic [5:0]        i_y1,
   input  logic [3:0]        i_color,
   input  logic              i_grant,
   output logic              o_req,
   output logic [FB_AW-1:0]  o_addr,
   output logic [31:0]       o_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   fill_state_t       r_state;
   fill_state_t       w_next;
   logic [6:0]        r_bx0;
   logic [6:0]        r_bx1;
   logic [5:0]        r_y1;
   logic [6:0]        r_cur_bx;
   logic [5:0]        r_cur_y;
   logic [FB_AW-1:0]  r_row_base;
   logic [3:0]        r_color;
   logic              r_err;
   logic              w_bad;
   logic              w_last_col;
   logic              w_last;

   assign w_bad = (i_bx0 > i_bx1) || (i_y0 > i_y1) ||
                  (i_bx1 > 7'd79) || (i_y1 > 6'd59);
   assign w_last_col = (r_cur_bx == r_bx1);
   assign w_last     = w_last_col && (r_cur_y == r_y1);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (i_start) w_next = w_bad ? DONE : RUN;
         RUN:  if (i_grant && w_last) w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bx0      <= '0;
         r_bx1      <= '0;
         r_y1       <= '0;
         r_cur_bx   <= '0;
         r_cur_y    <= '0;
         r_row_base <= '0;
         r_color    <= '0;
         r_err      <= 1'b0;
      end else if (r_state == IDLE && i_start) begin
         r_bx0      <= i_bx0;
         r_bx1      <= i_bx1;
         r_y1       <= i_y1;
         r_cur_bx   <= i_bx0;
         r_cur_y    <= i_y0;
         r_row_base <= row_base(i_y0);
         r_color    <= i_color;
         r_err      <= w_bad;
      end else if (r_state == RUN && i_grant && !w_last) begin
         if (w_last_col) begin
            r_cur_bx   <= r_bx0;
            r_cur_y    <= r_cur_y + 6'd1;
            r_row_base <= r_row_base + FB_AW'(FB_ROW_BYTES);
         end else begin
            r_cur_bx   <= r_cur_bx + 7'd1;
         end
      end
   end

   assign o_req  = (r_state == RUN);
   assign o_addr = r_row_base + {6'd0, r_cur_bx};
   assign o_data = {8{r_color}};
   assign o_busy = (r_state != IDLE);
   assign o_done = (r_state == DONE);
   assign o_err  = r_err;

endmodule

// File: rtl/vga_fb_ctrl.sv
// Framebuffer write-port controller: arbitrates CPU stores against the
// fill engine and registers the winning write.
module vga_fb_ctrl
   import vga_fb_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cpu_valid,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_data,
   input  logic [1:0]  i_cpu_size,
   output logic        o_cpu_ready,
   input  logic        i_fill_start,
   input  logic [6:0]  i_fill_bx0,
   input  logic [6:0]  i_fill_bx1,
   input  logic [5:0]  i_fill_y0,
   input  logic [5:0]  i_fill_y1,
   input  logic [3:0]  i_fill_color,
   output logic        o_fill_busy,
   output logic        o_fill_done,
   output logic        o_fill_err,
   output logic [31:0] o_pxlAddr,
   output logic [31:0] o_pxlData,
   output mem_ctrl_t   o_ctrlVGA
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic              w_fill_req;
   logic              w_force;
   logic              w_cpu_gnt;
   logic              w_fill_gnt;
   logic [FB_AW-1:0]  w_fill_addr;
   logic [31:0]       w_fill_data;
   logic [SW-1:0]     r_starve;
   logic [31:0]       r_addr;
   logic [31:0]       r_data;
   mem_ctrl_t         r_ctrl;

   vga_fill_engine u_fill (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_fill_start),
      .i_bx0   (i_fill_bx0),
      .i_bx1   (i_fill_bx1),
      .i_y0    (i_fill_y0),
      .i_y1    (i_fill_y1),
      .i_color (i_fill_color),
      .i_grant (w_fill_gnt),
      .o_req   (w_fill_req),
      .o_addr  (w_fill_addr),
      .o_data  (w_fill_data),
      .o_busy  (o_fill_busy),
      .o_done  (o_fill_done),
      .o_err   (o_fill_err)
   );

   assign w_force     = w_fill_req && (r_starve == SW'(STARVE_LIMIT));
   assign w_cpu_gnt   = !w_force && i_cpu_valid;
   assign w_fill_gnt  = w_fill_req && !w_cpu_gnt;
   assign o_cpu_ready = !w_force;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve <= '0;
      end else if (!w_fill_req || w_fill_gnt) begin
         r_starve <= '0;
      end else if (w_cpu_gnt && r_starve != SW'(STARVE_LIMIT)) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   // size 11 is accepted from the CPU but never reaches the memory
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr <= '0;
         r_data <= '0;
         r_ctrl <= '0;
      end else if (w_cpu_gnt) begin
         r_addr          <= i_cpu_addr;
         r_data          <= i_cpu_data;
         r_ctrl.memWrite <= (i_cpu_size != 2'b11);
         r_ctrl.size     <= i_cpu_size;
      end else if (w_fill_gnt) begin
         r_addr          <= {{(32-FB_AW){1'b0}}, w_fill_addr};
         r_data          <= w_fill_data;
         r_ctrl.memWrite <= 1'b1;
         r_ctrl.size     <= SIZE_B;
      end else begin
         r_ctrl.memWrite <= 1'b0;
      end
   end

   assign o_pxlAddr = r_addr;
   assign o_pxlData = r_data;
   assign o_ctrlVGA = r_ctrl;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Randomised bench for vga_fb_ctrl against a queue-based model of the
// expected framebuffer write stream.
module tb_vga_fb_ctrl;
   import vga_fb_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_data;
   logic [1:0]  cpu_size;
   logic        cpu_ready;
   logic        fill_start;
   logic [6:0]  fill_bx0;
   logic [6:0]  fill_bx1;
   logic [5:0]  fill_y0;
   logic [5:0]  fill_y1;
   logic [3:0]  fill_color;
   logic        fill_busy;
   logic        fill_done;
   logic        fill_err;
   logic [31:0] pxl_addr;
   logic [31:0] pxl_data;
   mem_ctrl_t   ctrl;

   always #5 clk = ~clk;

   vga_fb_ctrl #(.STARVE_LIMIT(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cpu_valid  (cpu_valid),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_data   (cpu_data),
      .i_cpu_size   (cpu_size),
      .o_cpu_ready  (cpu_ready),
      .i_fill_start (fill_start),
      .i_fill_bx0   (fill_bx0),
      .i_fill_bx1   (fill_bx1),
      .i_fill_y0    (fill_y0),
      .i_fill_y1    (fill_y1),
      .i_fill_color (fill_color),
      .o_fill_busy  (fill_busy),
      .o_fill_done  (fill_done),
      .o_fill_err   (fill_err),
      .o_pxlAddr    (pxl_addr),
      .o_pxlData    (pxl_data),
      .o_ctrlVGA    (ctrl)
   );

   int checks = 0;
   int fails  = 0;

   // model: 0 idle, 1 filling, 2 done-pulse cycle
   int         m_st = 0;
   int         m_wait_run = 0;
   int         q_fill[$];
   logic [3:0] m_color = '0;
   logic       m_err = 1'b0;

   int   obs_addr[$];
   int   obs_done = 0;
   bit   acc;
   bit   last_ready;

   logic [6:0] f_bx0;
   logic [6:0] f_bx1;
   logic [5:0] f_y0;
   logic [5:0] f_y1;
   logic [3:0] f_col;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_start();
      if (f_bx0 > f_bx1 || f_y0 > f_y1 || f_bx1 > 79 || f_y1 > 59) begin
         m_st  = 2;
         m_err = 1'b1;
      end else begin
         q_fill.delete();
         for (int y = int'(f_y0); y <= int'(f_y1); y++)
            for (int x = int'(f_bx0); x <= int'(f_bx1); x++)
               q_fill.push_back(y * 80 + x);
         m_color = f_col;
         m_st    = 1;
         m_err   = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit vld, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input bit st);
      bit          fill_req;
      bit          forced;
      bit          cg;
      bit          fg;
      bit          e_we;
      logic [31:0] e_a;
      logic [31:0] e_d;
      logic [1:0]  e_sz;
      rst        = r;
      cpu_valid  = vld;
      cpu_addr   = a;
      cpu_data   = d;
      cpu_size   = sz;
      fill_start = st;
      fill_bx0   = f_bx0;
      fill_bx1   = f_bx1;
      fill_y0    = f_y0;
      fill_y1    = f_y1;
      fill_color = f_col;
      #4;
      fill_req = (m_st == 1);
      forced   = fill_req && (m_wait_run == 4);
      chk("ready", 32'(cpu_ready), 32'(!forced));
      chk("busy", 32'(fill_busy), 32'(m_st != 0));
      chk("done", 32'(fill_done), 32'(m_st == 2));
      chk("err", 32'(fill_err), 32'(m_err));
      last_ready = cpu_ready;
      if (fill_done) obs_done++;
      cg   = vld && !forced;
      fg   = fill_req && !cg;
      acc  = cg;
      e_we = 1'b0;
      e_a  = '0;
      e_d  = '0;
      e_sz = '0;
      if (cg) begin
         e_we = (sz != 2'b11);
         e_a  = a;
         e_d  = d;
         e_sz = sz;
      end else if (fg) begin
         e_we = 1'b1;
         e_a  = 32'(q_fill.pop_front());
         e_d  = {8{m_color}};
         e_sz = 2'b00;
      end
      if (!fill_req || fg) m_wait_run = 0;
      else if (cg && m_wait_run < 4) m_wait_run++;
      if (r) begin
         m_st       = 0;
         m_err      = 1'b0;
         m_wait_run = 0;
         q_fill.delete();
         e_we       = 1'b0;
      end else begin
         case (m_st)
            0: if (st) model_start();
            1: if (fg && q_fill.size() == 0) m_st = 2;
            default: m_st = 0;
         endcase
      end
      @(posedge clk);
      #1;
      chk("memWrite", 32'(ctrl.memWrite), 32'(e_we));
      if (e_we) begin
         chk("addr", pxl_addr, e_a);
         chk("data", pxl_data, e_d);
         chk("size", 32'(ctrl.size), 32'(e_sz));
      end
      if (ctrl.memWrite) obs_addr.push_back(int'(pxl_addr));
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 32'h0, 2'b00, 0);
   endtask

   task automatic set_rect(input int bx0, input int bx1, input int y0,
                           input int y1, input int col);
      f_bx0 = 7'(bx0);
      f_bx1 = 7'(bx1);
      f_y0  = 6'(y0);
      f_y1  = 6'(y1);
      f_col = 4'(col);
   endtask

   task automatic run_out(input int limit);
      for (int n = 0; n < limit && m_st != 0; n++) idle();
      chk("finish_timeout", 32'(m_st), 32'd0);
   endtask

   initial begin
      int t2_exp[6];
      int nforced;
      int runlen;
      int nacc;
      logic [31:0] ca;
      logic [31:0] cd;
      t2_exp = '{82, 83, 84, 162, 163, 164};
      set_rect(0, 0, 0, 0, 0);
      rst = 1'b1;
      cpu_valid = 0; cpu_addr = 0; cpu_data = 0; cpu_size = 0;
      fill_start = 0; fill_bx0 = 0; fill_bx1 = 0;
      fill_y0 = 0; fill_y1 = 0; fill_color = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", pxl_addr, 32'h0);
      chk("rst_data", pxl_data, 32'h0);
      chk("rst_ctrl", 32'(ctrl), 32'h0);
      chk("rst_busy", 32'(fill_busy), 32'h0);
      chk("rst_err", 32'(fill_err), 32'h0);

      // single CPU word store
      step(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
      chk("t1_addr", pxl_addr, 32'h10);
      chk("t1_data", pxl_data, 32'hDEADBEEF);
      chk("t1_ctrl", 32'(ctrl), 32'b110);
      step(0, 1, 32'h20, 32'h1, 2'b11, 0);
      chk("t1_nowrite", 32'(ctrl.memWrite), 32'h0);

      // small rectangle
      set_rect(2, 4, 1, 2, 4'hA);
      obs_addr.delete(); obs_done = 0;
      step(0, 0, 0, 0, 0, 1);
      run_out(40);
      idle(); idle();
      chk("t2_count", 32'(obs_addr.size()), 32'd6);
      foreach (t2_exp[i])
         if (i < obs_addr.size()) chk("t2_addr", 32'(obs_addr[i]), 32'(t2_exp[i]));
      chk("t2_done", 32'(obs_done), 32'd1);
      chk("t2_busy", 32'(fill_busy), 32'd0);

      // full screen
      set_rect(0, 79, 0, 59, 4'h3);
      obs_addr.delete(); obs_done = 0;
      step(0, 0, 0, 0, 0, 1);
      run_out(6000);
      idle();
      chk("t3_count", 32'(obs_addr.size()), 32'd4800);
      if (obs_addr.size() > 0)
         chk("t3_last", 32'(obs_addr[obs_addr.size()-1]), 32'd4799);
      chk("t3_done", 32'(obs_done), 32'd1);
      chk("t3_err", 32'(fill_err), 32'd0);

      // CPU saturating the port while a fill waits
      set_rect(0, 19, 10, 10, 4'h5);
      step(0, 0, 0, 0, 0, 1);
      nforced = 0; runlen = 0; nacc = 0;
      ca = 32'h100; cd = 32'h5000_0000;
      for (int n = 0; n < 300 && m_st != 0; n++) begin
         step(0, 1, ca, cd, 2'b10, 0);
         if (!last_ready) begin
            nforced++;
            chk("t4_run", 32'(runlen), 32'd4);
            runlen = 0;
         end else begin
            runlen++;
         end
         if (acc) begin
            nacc++;
            ca = ca + 4;
            cd = cd + 1;
         end
      end
      chk("t4_forced", 32'(nforced), 32'd20);
      chk("t4_cpu_acc", 32'(nacc), 32'd81);
      idle();

      // rejected rectangles
      set_rect(10, 5, 0, 0, 1);
      obs_addr.delete(); obs_done = 0;
      step(0, 0, 0, 0, 0, 1);
      idle(); idle();
      chk("t5_err", 32'(fill_err), 32'd1);
      chk("t5_done", 32'(obs_done), 32'd1);
      chk("t5_nowr", 32'(obs_addr.size()), 32'd0);
      set_rect(0, 3, 0, 60, 1);
      obs_done = 0;
      step(0, 0, 0, 0, 0, 1);
      idle(); idle();
      chk("t5y_err", 32'(fill_err), 32'd1);
      chk("t5y_done", 32'(obs_done), 32'd1);
      chk("t5y_nowr", 32'(obs_addr.size()), 32'd0);

      // restart during RUN is ignored
      set_rect(0, 3, 20, 20, 7);
      step(0, 0, 0, 0, 0, 1);
      idle();
      set_rect(0, 79, 0, 59, 2);
      step(0, 0, 0, 0, 0, 1);
      run_out(40);
      idle();
      chk("t5r_count", 32'(obs_addr.size()), 32'd4);
      chk("t5r_err", 32'(fill_err), 32'd0);

      // reset in the middle of a fill
      set_rect(0, 19, 30, 30, 9);
      obs_addr.delete(); obs_done = 0;
      step(0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 20 && obs_addr.size() < 3; n++) idle();
      chk("t6_pre", 32'(obs_addr.size()), 32'd3);
      step(1, 0, 0, 0, 0, 0);
      chk("t6_wr", 32'(ctrl.memWrite), 32'd0);
      repeat (10) idle();
      chk("t6_count", 32'(obs_addr.size()), 32'd3);
      chk("t6_done", 32'(obs_done), 32'd0);
      chk("t6_busy", 32'(fill_busy), 32'd0);

      // random rectangles against random CPU traffic
      for (int it = 0; it < 30; it++) begin
         int bx0;
         int y0;
         bx0 = int'($urandom_range(0, 79));
         y0  = int'($urandom_range(0, 59));
         set_rect(bx0, bx0 + int'($urandom_range(0, 6)),
                  y0, y0 + int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)));
         if ($urandom_range(0, 7) == 0 && bx0 > 0) f_bx1 = 7'(bx0 - 1);
         step(0, 0, 0, 0, 0, 1);
         for (int n = 0; n < 400 && m_st != 0; n++) begin
            bit rs;
            rs = ($urandom_range(0, 15) == 0);
            if (rs) set_rect(int'($urandom_range(0, 79)), 79, 0, 59,
                             int'($urandom_range(0, 15)));
            step(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 8191)),
                 $urandom, 2'($urandom_range(0, 3)), rs);
         end
         chk("rnd_finish", 32'(m_st), 32'd0);
         repeat (int'($urandom_range(0, 3))) idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
